// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared types and sizes for the tile ROM arbiter
package tile_pkg;
  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 6;
  localparam int ROM_DEPTH    = 3072;
  localparam int STARVE_LIMIT = 8;

  typedef enum logic {
    PORT_D = 1'b0,
    PORT_A = 1'b1
  } port_e;

  typedef struct packed {
    logic              valid;
    port_e             port;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;
endpackage

// File: rtl/tile_rom_arbiter_if.sv
// rtl/tile_rom_arbiter_if.sv - requester, ROM and response signals of the tile ROM arbiter
interface tile_rom_arbiter_if import tile_pkg::*; ();
  logic              d_valid;
  logic [ADDR_W-1:0] d_addr;
  logic              d_ready;
  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              a_ready;
  logic [ADDR_W-1:0] rom_address;
  logic [DATA_W-1:0] rom_q;
  logic              rsp_valid;
  logic              rsp_port;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  modport slave (
    input  d_valid, d_addr, a_valid, a_addr, rom_q,
    output d_ready, a_ready, rom_address, rsp_valid, rsp_port, rsp_data, rsp_err
  );

  modport master (
    output d_valid, d_addr, a_valid, a_addr, rom_q,
    input  d_ready, a_ready, rom_address, rsp_valid, rsp_port, rsp_data, rsp_err
  );
endinterface

// File: rtl/tile_rom_arbiter_grant_logic.sv
// rtl/tile_rom_arbiter_grant_logic.sv - priority / round-robin grant with starvation guard
module tile_grant_logic import tile_pkg::*; #(
  parameter int LIMIT = STARVE_LIMIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_blank,
  input  logic i_d_valid,
  input  logic i_a_valid,
  output logic o_grant_d,
  output logic o_grant_a
);
  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  port_e            r_last_grant;
  logic             w_starved;
  logic             w_rr_a;

  assign w_starved = (r_starve_cnt == CNT_W'(LIMIT));
  // Round-robin only applies during blanking; active video favours the display.
  assign w_rr_a    = !i_blank && (r_last_grant == PORT_D);

  assign o_grant_a = i_a_valid && (!i_d_valid || w_starved || w_rr_a);
  assign o_grant_d = i_d_valid && !o_grant_a;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_starve_cnt <= '0;
      r_last_grant <= PORT_A;
    end else begin
      if (o_grant_a) begin
        r_starve_cnt <= '0;
        r_last_grant <= PORT_A;
      end else begin
        if (i_a_valid && !w_starved)
          r_starve_cnt <= r_starve_cnt + 1'b1;
        if (o_grant_d)
          r_last_grant <= PORT_D;
      end
    end
  end
endmodule

// File: rtl/tile_rom_arbiter.sv
// rtl/tile_rom_arbiter.sv - two-port tile ROM arbiter with a fixed 2-cycle tagged read pipeline
module tile_rom_arbiter import tile_pkg::*; (
  input  logic               i_vga_clk,
  input  logic               i_reset,
  input  logic               i_blank,
  tile_rom_arbiter_if.slave  bus
);
  logic              w_grant_d;
  logic              w_grant_a;
  logic              w_accept;
  logic [ADDR_W-1:0] w_addr;
  logic              w_err;

  logic              r_v1, r_v2;
  port_e             r_tag1, r_tag2;
  logic              r_err1, r_err2;
  logic [ADDR_W-1:0] r_rom_address;
  rsp_t              r_rsp;

  tile_grant_logic u_grant (
    .i_clk     (i_vga_clk),
    .i_rst     (i_reset),
    .i_blank   (i_blank),
    .i_d_valid (bus.d_valid),
    .i_a_valid (bus.a_valid),
    .o_grant_d (w_grant_d),
    .o_grant_a (w_grant_a)
  );

  assign w_accept = w_grant_d || w_grant_a;
  assign w_addr   = w_grant_a ? bus.a_addr : bus.d_addr;
  assign w_err    = (w_addr >= ADDR_W'(ROM_DEPTH));

  always_ff @(posedge i_vga_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rom_address <= '0;
      r_v1          <= 1'b0;
      r_tag1        <= PORT_D;
      r_err1        <= 1'b0;
      r_v2          <= 1'b0;
      r_tag2        <= PORT_D;
      r_err2        <= 1'b0;
      r_rsp         <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_rom_address <= w_addr;
        r_tag1        <= w_grant_a ? PORT_A : PORT_D;
        r_err1        <= w_err;
      end
      r_v2      <= r_v1;
      r_tag2    <= r_tag1;
      r_err2    <= r_err1;
      r_rsp.valid <= r_v2;
      // Port, error and data are held between responses.
      if (r_v2) begin
        r_rsp.port <= r_tag2;
        r_rsp.err  <= r_err2;
        r_rsp.data <= r_err2 ? '0 : bus.rom_q;
      end
    end
  end

  assign bus.d_ready     = w_grant_d;
  assign bus.a_ready     = w_grant_a;
  assign bus.rom_address = r_rom_address;
  assign bus.rsp_valid   = r_rsp.valid;
  assign bus.rsp_port    = r_rsp.port;
  assign bus.rsp_data    = r_rsp.data;
  assign bus.rsp_err     = r_rsp.err;
endmodule

// File: tb/tb_tile_rom_arbiter.sv
// tb/tb_tile_rom_arbiter.sv - directed vector bench for tile_rom_arbiter
module tb_tile_rom_arbiter;
  import tile_pkg::*;

  typedef struct {
    logic        bl;
    logic        dv;
    logic [12:0] da;
    logic        av;
    logic [12:0] aa;
    logic        edr;
    logic        ear;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic blank = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic chk_en = 1'b0;

  logic        cur_v = 1'b0;
  logic        cur_p = 1'b0;
  logic [12:0] cur_a = '0;
  logic        s1_v, s2_v, s3_v;
  logic        s1_p, s2_p, s3_p;
  logic [12:0] s1_a, s2_a, s3_a;

  vec_t tv[$];

  tile_rom_arbiter_if bus ();

  tile_rom_arbiter dut (
    .i_vga_clk (clk),
    .i_reset   (rst),
    .i_blank   (blank),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) bus.rom_q <= bus.rom_address[5:0];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected response pipeline: accept at edge k shows on rsp after edge k+2.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1_v, s2_v, s3_v} <= '0;
      {s1_p, s2_p, s3_p} <= '0;
      s1_a <= '0; s2_a <= '0; s3_a <= '0;
    end else begin
      s1_v <= cur_v; s1_p <= cur_p; s1_a <= cur_a;
      s2_v <= s1_v;  s2_p <= s1_p;  s2_a <= s1_a;
      s3_v <= s2_v;  s3_p <= s2_p;  s3_a <= s2_a;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rsp_valid", bus.rsp_valid, s3_v);
      if (s3_v) begin
        check("rsp_port", bus.rsp_port, s3_p);
        check("rsp_err", bus.rsp_err, s3_a >= 13'd3072);
        check("rsp_data", bus.rsp_data, (s3_a >= 13'd3072) ? 6'd0 : s3_a[5:0]);
      end
    end
  end

  task automatic cyc(input logic bl, input logic dv, input logic [12:0] da,
                     input logic av, input logic [12:0] aa,
                     input logic edr, input logic ear, input string nm);
    @(negedge clk);
    blank = bl;
    bus.d_valid = dv; bus.d_addr = da;
    bus.a_valid = av; bus.a_addr = aa;
    #1;
    check({nm, "_d_ready"}, bus.d_ready, edr);
    check({nm, "_a_ready"}, bus.a_ready, ear);
    cur_v = edr | ear;
    cur_p = ear;
    cur_a = ear ? aa : da;
    @(posedge clk);
    #1;
    cur_v = 1'b0;
    bus.d_valid = 1'b0;
    bus.a_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bus.d_valid = 1'b0; bus.d_addr = '0;
    bus.a_valid = 1'b0; bus.a_addr = '0;

    // latency: D only, blank=1
    for (int i = 0; i < 3; i++) tv.push_back('{1'b1, 1'b1, 13'(i), 1'b0, 13'd0, 1'b1, 1'b0});
    for (int i = 0; i < 2; i++) tv.push_back('{1'b1, 1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0});
    // starvation: D x8, A once, D x8
    for (int i = 0; i < 8; i++) tv.push_back('{1'b1, 1'b1, 13'(10 + i), 1'b1, 13'd200, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b1, 13'd18, 1'b1, 13'd200, 1'b0, 1'b1});
    for (int i = 0; i < 8; i++) tv.push_back('{1'b1, 1'b1, 13'(30 + i), 1'b1, 13'd201, 1'b1, 1'b0});
    tv.push_back('{1'b1, 1'b0, 13'd0, 1'b1, 13'd5, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) tv.push_back('{1'b0, 1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0});

    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rom_address", bus.rom_address, 13'd0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_port", bus.rsp_port, 1'b0);
    check("rst_rsp_data", bus.rsp_data, 6'd0);
    check("rst_rsp_err", bus.rsp_err, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;

    foreach (tv[i])
      cyc(tv[i].bl, tv[i].dv, tv[i].da, tv[i].av, tv[i].aa, tv[i].edr, tv[i].ear,
          $sformatf("vec%0d", i));

    // reset mid-stream drops the in-flight read
    do_reset();
    cyc(1'b1, 1'b1, 13'd100, 1'b0, 13'd0, 1'b1, 1'b0, "mid_acc");
    rst = 1'b1;
    #1;
    check("mid_rom_address", bus.rom_address, 13'd0);
    check("mid_rsp_valid", bus.rsp_valid, 1'b0);
    check("mid_rsp_port", bus.rsp_port, 1'b0);
    check("mid_rsp_data", bus.rsp_data, 6'd0);
    check("mid_rsp_err", bus.rsp_err, 1'b0);
    check("mid_d_ready", bus.d_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0, "mid_idle");

    // round-robin during blanking, starting from last_grant=A
    do_reset();
    cyc(1'b0, 1'b1, 13'd40, 1'b1, 13'd41, 1'b1, 1'b0, "rr0");
    cyc(1'b0, 1'b1, 13'd42, 1'b1, 13'd41, 1'b0, 1'b1, "rr1");
    cyc(1'b0, 1'b1, 13'd42, 1'b1, 13'd43, 1'b1, 1'b0, "rr2");
    cyc(1'b0, 1'b1, 13'd44, 1'b1, 13'd43, 1'b0, 1'b1, "rr3");

    // out-of-range then last valid address
    cyc(1'b0, 1'b0, 13'd0, 1'b1, 13'd3072, 1'b0, 1'b1, "oor0");
    cyc(1'b0, 1'b0, 13'd0, 1'b1, 13'd3071, 1'b0, 1'b1, "oor1");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0, "oor_idle");

    // blank falls with last_grant=D: A wins immediately
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 13'(50 + i), 1'b1, 13'd60, 1'b1, 1'b0, "blk_hi");
    cyc(1'b0, 1'b1, 13'd54, 1'b1, 13'd60, 1'b0, 1'b1, "blank_c5");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 13'd0, 1'b0, 13'd0, 1'b0, 1'b0, "blk_idle");

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tile_rom_arbiter.md
Name: tile_rom_arbiter

Overview:
Shares one synchronous single-port tile-pixel ROM (palette-index data) between two requesters: the display fetch path (port D) and an auxiliary requester such as collision or blitter logic (port A). It is a fully pipelined arbiter that issues one ROM read per cycle and returns tagged data with a fixed 2-cycle latency. It sits between the tile/sprite mappers and the tile ROM, ahead of the palette lookup.

Parameters:
ADDR_W, 13, ROM address width
DATA_W, 6, ROM word width (palette index)
ROM_DEPTH, 3072, number of valid ROM words (48x64); addresses at or above this are out of range
STARVE_LIMIT, 8, consecutive cycles of port A being denied before it is forced to win

Ports:
vga_clk  in  1  single clock for all state
reset  in  1  asynchronous, active-high reset
blank  in  1  1 = active video (display priority), 0 = blanking interval
d_valid  in  1  display request valid
d_addr  in  ADDR_W  display request address
d_ready  out  1  display request accepted this cycle
a_valid  in  1  auxiliary request valid
a_addr  in  ADDR_W  auxiliary request address
a_ready  out  1  auxiliary request accepted this cycle
rom_address  out  ADDR_W  registered address to the ROM
rom_q  in  DATA_W  ROM data, valid one cycle after rom_address is presented
rsp_valid  out  1  response valid
rsp_port  out  1  response owner: 0 = D, 1 = A
rsp_data  out  DATA_W  response data
rsp_err  out  1  the request address was out of range; rsp_data forced to 0

Behaviour:
- Reset (async, any time): rom_address=0, rsp_valid=0, rsp_port=0, rsp_data=0, rsp_err=0, the pipeline valid bits are cleared, starve_cnt=0, and last_grant=A. In-flight reads are dropped and never responded to.
- Handshake: a request is accepted when x_valid and x_ready are both high at a rising edge. d_ready and a_ready are combinational functions of d_valid, a_valid, blank, starve_cnt and last_grant. At most one of them is high in any cycle. A requester holds valid and addr stable until it is accepted.
- Grant priority, evaluated each cycle:
  1. If only one port is valid, that port is granted.
  2. If both are valid and starve_cnt == STARVE_LIMIT, A is granted.
  3. If both are valid and blank=1, D is granted.
  4. If both are valid and blank=0, round-robin: the port opposite to last_grant is granted.
- last_grant updates on every accepted request.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each cycle with a_valid=1 and a_ready=0.
  - Clears on A acceptance.
  - Holds when a_valid=0.
- Pipeline (accept at edge k):
  - Edge k: rom_address <= granted addr, v1<=1, tag1<=port, err1<=(addr >= ROM_DEPTH).
  - Edge k+1: v2<=v1, tag2<=tag1, err2<=err1; the ROM captures rom_address.
  - Edge k+2: rsp_valid<=v2, rsp_port<=tag2, rsp_err<=err2, rsp_data<=(err2 ? 0 : rom_q).
  - Latency is exactly 2 cycles from the accepting edge to rsp_valid high. Throughput is 1 per cycle. Responses are never back-pressured, and their order matches acceptance order.
- With no accept at edge k, v1<=0 and rom_address holds its prior value.
- Out-of-range addresses are still accepted. The ROM is still read, but the data is discarded.
- A blank edge takes effect on the same cycle's arbitration. A request already accepted is unaffected.
- rsp_valid is a single-cycle pulse per request. rsp_data and rsp_port hold their values when rsp_valid=0.

Decomposition:
- Shared package tile_pkg: ADDR_W, DATA_W, ROM_DEPTH, the port_e enum {PORT_D=0, PORT_A=1}, and the packed struct rsp_t {valid, port, err, data}.
- One sub-module, tile_grant_logic: combinational priority/round-robin decision plus the starve_cnt and last_grant registers. It outputs grant_d and grant_a.
- The top level holds the 2-stage pipeline and the response register. The ROM itself stays external.

Test Plan:
- Reset mid-stream:
  - Stimulus: D accepted at edge 3 with addr 100, then reset asserted between edges 3 and 4, then released.
  - Required: rsp_valid stays 0 through edge 6, and all outputs are 0 while reset is asserted.
- Latency:
  - Stimulus: blank=1, only D valid, addrs 0,1,2 on consecutive cycles, ROM model q=addr[5:0].
  - Required: rsp_valid high at edges 2,3,4 after the first accept, with rsp_data 0,1,2 and rsp_port=0.
- Starvation:
  - Stimulus: blank=1, both ports valid continuously.
  - Required: D wins 8 consecutive cycles, A is accepted on the 9th, then D wins 8 more.
- Round-robin:
  - Stimulus: blank=0, both ports valid, last_grant=A after reset.
  - Required: grants alternate D,A,D,A, and rsp_port alternates 0,1,0,1 two cycles later.
- Out-of-range:
  - Stimulus: A requests addr 3072, then addr 3071 (q=0x3F).
  - Required: first response rsp_err=1, rsp_data=0; second response rsp_err=0, rsp_data=0x3F.
- Blank toggle:
  - Stimulus: both ports valid, blank falls 1→0 at cycle 5 with last_grant=D.
  - Required: A is granted at cycle 5, and d_ready=0 that cycle.
